// File: rtl/snake_cmd_fifo_pkg.sv
// Shared constants for the HPS command buffer in front of snake_fpga.
// RESET_GAME mirrors the snake_fpga command encoding in snake_consts.svh.
package snake_cmd_fifo_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned LEVEL_W = 8;

    localparam logic [DATA_W-1:0] RESET_GAME = 32'hF000_0000;

    localparam int unsigned FIFO_STAT_EMPTY_BIT  = 8;
    localparam int unsigned FIFO_STAT_FULL_BIT   = 9;
    localparam int unsigned FIFO_STAT_HWM_OFFSET = 16;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_CMD  = 4'd0,
        ADDR_CTRL = 4'd1
    } fifo_addr_e;

endpackage

// File: rtl/snake_cmd_fifo_if.sv
// Avalon-MM write/read bundle, used both for the HPS slave side and the snake_fpga master side.
interface snake_cmd_fifo_if;
    import snake_cmd_fifo_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output waitrequest
    );

endinterface

// File: rtl/snake_cmd_fifo_sync_fifo.sv
// Generic first-word-fall-through FIFO with a flush-and-load port that
// replaces the whole contents with a single word in one cycle.
module snake_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush_load,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned      PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == DEPTH_CNT);
    assign empty_c = (count == '0);
    assign do_push = push & ~full_c & ~flush_load;
    assign do_pop  = pop & ~empty_c & ~flush_load;
    assign rdata_c = mem[rd_ptr];

    // Flush keeps rd_ptr and reloads the head slot, so the new word is the only entry.
    always_comb begin
        wr_ptr_next  = wr_ptr;
        rd_ptr_next  = rd_ptr;
        count_next_c = count;
        if (flush_load) begin
            wr_ptr_next  = rd_ptr + PTR_W'(1);
            count_next_c = CNT_W'(1);
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_next_c = count + CNT_W'(1);
                2'b01:   count_next_c = count - CNT_W'(1);
                default: count_next_c = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next_c;
        end
    end

    // Storage carries no reset so it can map onto MLAB/register-file primitives.
    always_ff @(posedge clk) begin
        if (flush_load) begin
            mem[rd_ptr] <= wdata;
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/snake_cmd_fifo.sv
// HPS-to-snake_fpga command buffer: single-cycle HPS writes, in-order replay
// on an Avalon-MM master, RESET_GAME flush, occupancy/high-water status.
module snake_cmd_fifo
    import snake_cmd_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    snake_cmd_fifo_if.slave    s,
    snake_cmd_fifo_if.master   m,
    output logic [LEVEL_W-1:0] level_export
);

    logic              cmd_sel;
    logic              ctrl_wr;
    logic              is_reset_word;
    logic              stall_c;
    logic              accept;
    logic              push;
    logic              pop;
    logic              flush_load;
    logic [DATA_W-1:0] head_c;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next_c;
    logic [CNT_W-1:0]  hwm;
    logic              full_c;
    logic              empty_c;
    logic [DATA_W-1:0] status_c;

    assign cmd_sel       = (s.address == ADDR_CMD);
    assign ctrl_wr       = s.write & (s.address == ADDR_CTRL);
    assign is_reset_word = (s.writedata == RESET_GAME);

    // A reset word must always get through, even into a full queue.
    assign stall_c    = s.write & cmd_sel & full_c & ~is_reset_word;
    assign accept     = s.write & cmd_sel & ~stall_c;
    assign flush_load = accept & is_reset_word;
    assign push       = accept & ~is_reset_word;
    assign pop        = ~empty_c & ~m.waitrequest;

    snake_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .pop          (pop),
        .flush_load   (flush_load),
        .wdata        (s.writedata),
        .rdata_c      (head_c),
        .count        (count),
        .count_next_c (count_next_c),
        .full_c       (full_c),
        .empty_c      (empty_c)
    );

    // High-water mark; a control-register write rebases it to the live occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hwm <= '0;
        end else if (ctrl_wr) begin
            hwm <= count;
        end else if (count_next_c > hwm) begin
            hwm <= count_next_c;
        end
    end

    always_comb begin
        status_c                                   = '0;
        status_c[7:0]                              = 8'(count);
        status_c[FIFO_STAT_EMPTY_BIT]              = empty_c;
        status_c[FIFO_STAT_FULL_BIT]               = full_c;
        status_c[FIFO_STAT_HWM_OFFSET +: 8]        = 8'(hwm);
    end

    assign s.readdata    = cmd_sel ? status_c : '0;
    assign s.waitrequest = stall_c;

    assign m.address   = '0;
    assign m.read      = 1'b0;
    assign m.write     = ~empty_c;
    assign m.writedata = head_c;

    assign level_export = LEVEL_W'(count);

endmodule

// File: tb/tb_snake_cmd_fifo.sv
// Directed bench for snake_cmd_fifo: queue-based model checked every cycle plus literal checkpoints.
module tb_snake_cmd_fifo;
    import snake_cmd_fifo_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] level_export;

    snake_cmd_fifo_if s_bus ();
    snake_cmd_fifo_if m_bus ();

    snake_cmd_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s            (s_bus),
        .m            (m_bus),
        .level_export (level_export)
    );

    always #5 clk = ~clk;

    logic [31:0] mq[$];
    logic [31:0] seen[$];
    int          m_hwm;
    bit          started;
    int          n_checks;
    int          n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: what the queue holds after each edge, from the command rules alone.
    always @(posedge clk) begin : model
        int sz;
        bit rg;
        bit acc;
        bit popq;
        if (!reset_n) begin
            mq.delete();
            m_hwm   = 0;
            started = 1'b1;
        end else if (started) begin
            sz   = mq.size();
            rg   = (s_bus.writedata == RESET_GAME);
            acc  = s_bus.write && s_bus.address == 4'd0 && !(sz == DEPTH && !rg);
            popq = (sz != 0) && !m_bus.waitrequest;
            if (acc && rg) begin
                mq.delete();
                mq.push_back(RESET_GAME);
            end else begin
                if (popq) void'(mq.pop_front());
                if (acc) mq.push_back(s_bus.writedata);
            end
            if (s_bus.write && s_bus.address == 4'd1) m_hwm = sz;
            else if (mq.size() > m_hwm) m_hwm = mq.size();
        end
    end

    always @(negedge clk) begin : compare
        int          exp_sz;
        logic        exp_stall;
        logic [31:0] exp_status;
        if (started && reset_n) begin
            exp_sz = mq.size();
            check("m_write", 32'(m_bus.write), 32'(exp_sz != 0));
            if (exp_sz != 0) check("m_writedata", m_bus.writedata, mq[0]);
            check("m_address", 32'(m_bus.address), 32'h0);
            check("m_read", 32'(m_bus.read), 32'h0);
            check("level_export", 32'(level_export), 32'(exp_sz));
            exp_stall = s_bus.write && s_bus.address == 4'd0 && exp_sz == DEPTH
                        && s_bus.writedata != RESET_GAME;
            check("s_waitrequest", 32'(s_bus.waitrequest), 32'(exp_stall));
            exp_status = (s_bus.address == 4'd0)
                ? {8'h0, 8'(m_hwm), 6'h0, exp_sz == DEPTH, exp_sz == 0, 8'(exp_sz)} : 32'h0;
            check("s_readdata", s_bus.readdata, exp_status);
            if (m_bus.write && !m_bus.waitrequest) seen.push_back(m_bus.writedata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        int guard;
        guard = 0;
        s_bus.address   = 4'd0;
        s_bus.write     = 1'b1;
        s_bus.writedata = w;
        #1;
        while (s_bus.waitrequest && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got stalled %0d cycles expected accept", guard);
        end
        step();
        s_bus.write = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        s_bus.write = 1'b0;
        m_bus.waitrequest = 1'b0;
        while (mq.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        step();
    endtask

    task automatic check_seen(input string name, input logic [31:0] first, input int n);
        check({name, "_len"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++)
            check(name, seen[i], first + 32'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        started  = 1'b0;
        reset_n  = 1'b0;
        s_bus.address = 4'd0;
        s_bus.read = 1'b0;
        s_bus.write = 1'b0;
        s_bus.writedata = 32'h0;
        m_bus.waitrequest = 1'b0;
        m_bus.readdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", s_bus.readdata, 32'h0000_0100);
        check("reset_m_write", 32'(m_bus.write), 32'h0);
        check("reset_level", 32'(level_export), 32'h0);
        check("reset_waitreq", 32'(s_bus.waitrequest), 32'h0);
        reset_n = 1'b1;
        step();

        // Burst with no backpressure
        seen.delete();
        push(32'h1);
        check("first_latency_m_write", 32'(m_bus.write), 32'h1);
        check("first_latency_data", m_bus.writedata, 32'h1);
        for (int i = 2; i <= 5; i++) push(32'(i));
        drain();
        check_seen("burst_order", 32'h1, 5);
        check("burst_status", s_bus.readdata, 32'h0001_0100);

        // Backpressure: 17 pushes into DEPTH=16
        seen.delete();
        m_bus.waitrequest = 1'b1;
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
        s_bus.address = 4'd0; s_bus.writedata = 32'h110; s_bus.write = 1'b1;
        #1;
        check("bp_stall", 32'(s_bus.waitrequest), 32'h1);
        repeat (3) step();
        check("bp_stall_held", 32'(s_bus.waitrequest), 32'h1);
        check("bp_status_full", s_bus.readdata, 32'h0010_0210);
        m_bus.waitrequest = 1'b0;
        #1;
        check("bp_stall_on_pop", 32'(s_bus.waitrequest), 32'h1);
        step();
        check("bp_level_after_pop", 32'(level_export), 32'd15);
        check("bp_stall_released", 32'(s_bus.waitrequest), 32'h0);
        step();
        s_bus.write = 1'b0;
        drain();
        check_seen("bp_order", 32'h100, 17);

        // Simultaneous push and pop at count 3
        seen.delete();
        m_bus.waitrequest = 1'b1;
        push(32'h31); push(32'h32); push(32'h33);
        m_bus.waitrequest = 1'b0;
        push(32'h34);
        check("pp_level_a", 32'(level_export), 32'd3);
        push(32'h35);
        check("pp_level_b", 32'(level_export), 32'd3);
        drain();
        check_seen("pp_order", 32'h31, 5);

        // Flush with 10 queued and head stalled
        seen.delete();
        m_bus.waitrequest = 1'b1;
        for (int i = 0; i < 10; i++) push(32'h41 + 32'(i));
        push(RESET_GAME);
        check("flush_head", m_bus.writedata, RESET_GAME);
        check("flush_level", 32'(level_export), 32'd1);
        drain();
        check_seen("flush_only_reset", RESET_GAME, 1);
        check("flush_status", s_bus.readdata, 32'h0010_0100);

        // Flush while full
        seen.delete();
        m_bus.waitrequest = 1'b1;
        for (int i = 0; i < 16; i++) push(32'h51 + 32'(i));
        s_bus.address = 4'd0; s_bus.writedata = RESET_GAME; s_bus.write = 1'b1;
        #1;
        check("flushfull_no_stall", 32'(s_bus.waitrequest), 32'h0);
        step();
        s_bus.write = 1'b0;
        check("flushfull_level", 32'(level_export), 32'd1);
        drain();
        check_seen("flushfull_only_reset", RESET_GAME, 1);

        // Address-1 read
        s_bus.address = 4'd1; s_bus.read = 1'b1;
        #1;
        check("ctrl_read", s_bus.readdata, 32'h0);
        s_bus.read = 1'b0; s_bus.address = 4'd0;

        // Reset mid-stream
        m_bus.waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) push(32'h61 + 32'(i));
        reset_n = 1'b0;
        step();
        check("midrst_m_write", 32'(m_bus.write), 32'h0);
        check("midrst_readdata", s_bus.readdata, 32'h0000_0100);
        check("midrst_level", 32'(level_export), 32'h0);
        reset_n = 1'b1;
        step();

        // hwm rebased by an address-1 write
        push(32'h71); push(32'h72); push(32'h73);
        m_bus.waitrequest = 1'b0;
        step();
        m_bus.waitrequest = 1'b1;
        #1;
        check("hwm_before_clear", s_bus.readdata, 32'h0003_0002);
        s_bus.address = 4'd1; s_bus.writedata = 32'hDEAD_BEEF; s_bus.write = 1'b1;
        step();
        s_bus.write = 1'b0; s_bus.address = 4'd0;
        #1;
        check("hwm_after_clear", s_bus.readdata, 32'h0002_0002);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
